// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset pc,
// queue depth and the run/halt state encoding.
package fetch_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int DATA_WIDTH        = 32;

  localparam logic [DATA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int FETCH_QDEPTH = 2;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port and decoder-facing instruction handshake.
// The master side is the fetch stage; the slave side is memory plus decoder.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic                         imem_req;
  logic [DATA_WIDTH-1:0]        imem_addr;
  logic                         imem_gnt;
  logic                         imem_rvalid;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata;

  logic                         instr_valid;
  logic                         instr_ready;
  logic [INSTRUCTION_WIDTH-1:0] instr_out;
  logic [DATA_WIDTH-1:0]        instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO with flush; head is read straight from storage,
// so a pushed entry becomes visible the cycle after the push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [FETCH_QDEPTH];
  logic [WIDTH-1:0] mem_d [FETCH_QDEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(FETCH_QDEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the pc, issues instruction-memory reads, buffers returned
// words with their pc tags and hands them to the decoder; redirects flush.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int                    MAX_OUTSTANDING = FETCH_QDEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instruction_fetch_if.master   bus,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fetch_error
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
  logic [1:0]            inflight_q, inflight_d;
  logic [1:0]            discard_q, discard_d;
  logic                  fetch_error_q, fetch_error_d;
  logic                  armed_q, armed_d;

  logic                  redirect_apply, redirect_bad;
  logic                  pop, resp, resp_keep, grant;
  logic [2:0]            credits_used;
  logic [1:0]            buf_count, tag_count;
  logic [DATA_WIDTH-1:0] tag_head;

  // Reads still in flight (including ones to be discarded) plus buffered words
  // share the credit pool; a word leaving the buffer this cycle frees its credit.
  always_comb begin
    redirect_apply = redirect_valid && (state_q == FETCH_RUN);
    redirect_bad   = redirect_apply && (redirect_pc[1:0] != 2'b00);
    pop            = bus.instr_valid && bus.instr_ready;
    resp           = bus.imem_rvalid && (inflight_q != 2'd0);
    resp_keep      = resp && (discard_q == 2'd0) && (tag_count != 2'd0) && !redirect_apply;
    credits_used   = {1'b0, inflight_q} + {1'b0, buf_count} - {2'b00, pop};
    bus.imem_req   = armed_q && (state_q == FETCH_RUN) && !redirect_valid &&
                     (credits_used < 3'(MAX_OUTSTANDING));
    grant          = bus.imem_req && bus.imem_gnt;
  end

  // After a redirect every read still in flight is stale, so the discard count
  // simply becomes the post-update in-flight count.
  always_comb begin
    state_d       = state_q;
    fpc_d         = fpc_q;
    fetch_error_d = fetch_error_q;
    armed_d       = 1'b1;
    inflight_d    = inflight_q + {1'b0, grant} - {1'b0, resp};
    discard_d     = discard_q - {1'b0, resp && (discard_q != 2'd0)};
    if (redirect_apply) begin
      inflight_d = inflight_q - {1'b0, resp};
      discard_d  = inflight_q - {1'b0, resp};
      if (redirect_bad) begin
        fetch_error_d = 1'b1;
        state_d       = FETCH_HALT;
      end else begin
        fpc_d = redirect_pc;
      end
    end else if (grant) begin
      fpc_d = fpc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH_RUN;
      fpc_q         <= RESET_PC;
      inflight_q    <= 2'd0;
      discard_q     <= 2'd0;
      fetch_error_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      discard_q     <= discard_d;
      fetch_error_q <= fetch_error_d;
      armed_q       <= armed_d;
    end
  end

  fetch_buffer #(.WIDTH(DATA_WIDTH)) u_tag_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_apply),
    .push      (grant),
    .push_data (fpc_q),
    .pop       (resp_keep),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_buffer #(.WIDTH(DATA_WIDTH + INSTRUCTION_WIDTH)) u_instr_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_apply),
    .push      (resp_keep),
    .push_data ({tag_head, bus.imem_rdata}),
    .pop       (pop),
    .head      ({bus.instr_pc, bus.instr_out}),
    .count     (buf_count)
  );

  assign bus.imem_addr   = fpc_q;
  assign bus.instr_valid = (buf_count != 2'd0);
  assign fetch_error     = fetch_error_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory
// of configurable latency and grant behaviour.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_error;

  int check_count = 0;
  int pass_count  = 0;
  int mem_lat     = 1;
  int grant_count = 0;
  int cyc         = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC        (32'h0000_0000),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_error    (fetch_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00a0_0113;
      default:       return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
    endcase
  endfunction

  // In-order memory: a read granted at an edge answers mem_lat cycles later.
  always @(posedge clk) begin
    if (!reset_n) begin
      pend_q.delete();
      grant_count = 0;
      cyc = 0;
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end else begin
      if (bus.imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
      if (bus.imem_req && bus.imem_gnt) begin
        pend_q.push_back(pend_t'{addr: bus.imem_addr, due: cyc + mem_lat});
        grant_count++;
      end
      cyc++;
      #1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memWord(pend_q[0].addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid  = rv;
    redirect_pc     = rpc;
    bus.instr_ready = rdy;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_valid) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_req",   64'(bus.imem_req),    64'd0);
    checkOutput("rst_addr",  64'(bus.imem_addr),   64'd0);
    checkOutput("rst_valid", 64'(bus.instr_valid), 64'd0);
    checkOutput("rst_out",   64'(bus.instr_out),   64'd0);
    checkOutput("rst_pc",    64'(bus.instr_pc),    64'd0);
    checkOutput("rst_err",   64'(fetch_error),     64'd0);
    reset_n = 1'b1;

    // Reset then stream at one instruction per cycle
    @(negedge clk);
    checkOutput("t1_first_req", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'h0});
    waitValid("t1_w0");
    checkOutput("t1_word0", {bus.instr_pc, bus.instr_out}, {32'h0, 32'h0050_0093});
    @(negedge clk);
    checkOutput("t1_valid1", 64'(bus.instr_valid), 64'd1);
    checkOutput("t1_word1", {bus.instr_pc, bus.instr_out}, {32'h4, 32'h00a0_0113});
    @(negedge clk);
    checkOutput("t1_valid2", 64'(bus.instr_valid), 64'd1);
    checkOutput("t1_word2", {bus.instr_pc, bus.instr_out}, {32'h8, 32'hC0DE_0008});

    // Back-pressure
    bus.instr_ready = 1'b0;
    doReset();
    waitValid("t2_w0");
    checkOutput("t2_word0", {bus.instr_pc, bus.instr_out}, {32'h0, 32'h0050_0093});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2_hold", {bus.instr_pc, bus.instr_out}, {32'h0, 32'h0050_0093});
    end
    checkOutput("t2_grants", 64'(grant_count), 64'd2);
    checkOutput("t2_req_off", 64'(bus.imem_req), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t2_word1", {bus.instr_pc, bus.instr_out}, {32'h4, 32'h00a0_0113});

    // Redirect with two reads in flight
    mem_lat = 3;
    doReset();
    repeat (3) @(negedge clk);
    checkOutput("t3_inflight", {31'd0, bus.imem_req, 32'(grant_count)}, {31'd0, 1'b0, 32'd2});
    applyStimulus(1'b1, 32'h100, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_addr", 64'(bus.imem_addr), 64'h100);
    checkOutput("t3_valid_off", 64'(bus.instr_valid), 64'd0);
    waitValid("t3_wt");
    checkOutput("t3_target", {bus.instr_pc, bus.instr_out}, {32'h100, 32'hC0DE_0100});

    // Redirect in the same cycle as a pop at pc 0x8
    mem_lat = 1;
    doReset();
    begin
      int n = 0;
      while (!(bus.instr_valid && bus.instr_pc == 32'h8) && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("t4_pop_valid", 64'(bus.instr_valid), 64'd1);
    checkOutput("t4_pop_word", {bus.instr_pc, bus.instr_out}, {32'h8, 32'hC0DE_0008});
    applyStimulus(1'b1, 32'h200, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4_valid_off", 64'(bus.instr_valid), 64'd0);
    checkOutput("t4_req", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'h200});
    waitValid("t4_wt");
    checkOutput("t4_target", {bus.instr_pc, bus.instr_out}, {32'h200, 32'hC0DE_0200});

    // Misaligned redirect halts until reset
    @(negedge clk);
    applyStimulus(1'b1, 32'h102, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t5_halt", {61'd0, fetch_error, bus.imem_req, bus.instr_valid}, {61'd0, 3'b100});
      @(negedge clk);
    end
    applyStimulus(1'b1, 32'h300, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_still_halt", {61'd0, fetch_error, bus.imem_req, bus.instr_valid}, {61'd0, 3'b100});
      @(negedge clk);
    end
    checkOutput("t5_addr_align", 64'(bus.imem_addr[1:0]), 64'd0);

    // Asynchronous reset clears the halt; then grant stall and wrap
    reset_n      = 1'b0;
    bus.imem_gnt = 1'b0;
    #1;
    checkOutput("t6_async_rst", {61'd0, fetch_error, bus.imem_req, bus.instr_valid}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_stall_hold", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'h0});
    end
    checkOutput("t6_no_grant", 64'(grant_count), 64'd0);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    bus.imem_gnt = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t6_req_target", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'hFFFF_FFFC});
    waitValid("t6_wt");
    checkOutput("t6_top_word", {bus.instr_pc, bus.instr_out}, {32'hFFFF_FFFC, 32'hC0DE_FFFC});
    @(negedge clk);
    checkOutput("t6_wrap_valid", 64'(bus.instr_valid), 64'd1);
    checkOutput("t6_wrap_word", {bus.instr_pc, bus.instr_out}, {32'h0, 32'h0050_0093});

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
